// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, legal byte-enable patterns, data width,
// and be_legal(), which checks a byte-enable pattern against the low
// address bits.
package mips_mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] BE_W  = 4'b1111;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A lane pattern is legal when it is a naturally aligned word, halfword
    // or byte, and its lowest enabled lane matches the byte offset.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        case (be)
            BE_W:    ok = (addr_lo == 2'd0);
            BE_H0:   ok = (addr_lo == 2'd0);
            BE_H1:   ok = (addr_lo == 2'd2);
            4'b0001: ok = (addr_lo == 2'd0);
            4'b0010: ok = (addr_lo == 2'd1);
            4'b0100: ok = (addr_lo == 2'd2);
            4'b1000: ok = (addr_lo == 2'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Word-wide RAM with per-byte write enables and one registered read port.
// Latency: write and read both take effect on the clock edge; rdata is valid the cycle after re.
// Backpressure: none; accepts an access every cycle.
//
// Ports: clk; we[3:0] byte-lane write enables; re read enable; addr word
// address; wdata write data; rdata registered read data (holds when re=0).
// Contents are not reset.
module mem_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: one request at a time, WAIT_CYC wait states, then RAM access.
// Latency: rsp_valid is sampled high WAIT_CYC+1 edges after the acceptance edge; one request per WAIT_CYC+2 cycles.
// Backpressure: req_ready only in IDLE (initiator holds the request); no response backpressure, rsp_valid is a 1-cycle strobe.
//
// Ports: clk, rst (async, active high); req_valid/req_ready handshake with
// req_we, req_addr (byte address), req_wdata, req_be; rsp_valid strobe with
// rsp_rdata (holds between responses) and rsp_err; busy from acceptance
// through the response cycle.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYC);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic        commit;

    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    // Forces rsp_rdata to zero after reset and after an errored read,
    // without needing a reset on the RAM output register.
    logic        rdata_clr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt + 4'd1 == WAIT_LIM) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_be    = lat_be;
        end
        cur_err = !be_legal(cur_be, cur_addr[1:0]) || (|cur_addr[31:ADDR_W+2]);
        // Write and read capture happen on the edge that enters RESP.
        commit  = (state_nxt == RESP) && (state != RESP);
        ram_we  = (commit && cur_we && !cur_err) ? cur_be : 4'b0000;
        ram_re  = commit && !cur_we && !cur_err;
    end

    // Wait counter and request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            if (state_nxt == IDLE) begin
                wait_cnt <= 4'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
        end
    end

    // Response qualifiers; rdata only moves on read responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err   <= 1'b0;
            rdata_clr <= 1'b1;
        end else if (commit) begin
            rsp_err <= cur_err;
            if (!cur_we) begin
                rdata_clr <= cur_err;
            end
        end
    end

    assign rsp_rdata = rdata_clr ? 32'd0 : ram_rdata;

    mem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_addr[ADDR_W+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

endmodule
